// File: rtl/rs_drv_pkg.sv
// rs_drv_pkg
// Shared types and constants for the rs_ff command driver.
//   rs_op_t        : command opcode as carried on cmd_op
//   rs_drv_state_t : driver FSM states
//   OP_*           : raw opcode encodings
//   maxInt/widthFor: helpers for sizing counters from parameters
package rs_drv_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    RS_NOP    = OP_NOP,
    RS_SET    = OP_SET,
    RS_RESET  = OP_RESET,
    RS_TOGGLE = OP_TOGGLE
  } rs_op_t;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } rs_drv_state_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..maxVal, never less than one bit so a
  // zero-valued parameter still yields a legal vector.
  function automatic int widthFor(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/rs_drv_timer.sv
// rs_drv_timer
// Loadable down-counter shared by the DRIVE and SETTLE phases.
//   clk, rst : clock and synchronous active-high reset
//   load     : reload the counter with load_val this edge (wins over counting)
//   load_val : value to load
//   zero     : counter currently reads zero
// The counter stops at zero instead of wrapping.
module rs_drv_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: a load takes priority, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rs_ff_driver.sv
// rs_ff_driver
// Turns set/reset/toggle/no-op commands into bounded, never-overlapping
// s/r pulses for an rs_ff, reads q/qb back and retries on mismatch.
//   clk, rst             : clock and synchronous active-high reset
//   cmd_valid, cmd_op    : command handshake input (accepted when cmd_ready)
//   cmd_ready            : high only while idle
//   s, r                 : registered drive to the rs_ff
//   q_fb, qb_fb          : rs_ff outputs, same clock domain
//   done                 : one-cycle completion pulse
//   err, err_clr         : sticky failure flag and its clear
//   busy                 : any state other than idle
module rs_ff_driver
  import rs_drv_pkg::*;
#(
  parameter int PULSE_W    = 2,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_RETRY  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       s,
  output logic       r,
  input  logic       q_fb,
  input  logic       qb_fb,
  output logic       done,
  output logic       err,
  input  logic       err_clr,
  output logic       busy
);

  localparam int CW = widthFor(maxInt(PULSE_W, SETTLE_CYC));
  localparam int RW = widthFor(MAX_RETRY);

  // The timer is loaded with length-1 so that its zero flag marks the
  // last cycle of the phase and the FSM leaves on that edge.
  localparam logic [CW-1:0] PULSE_LOAD  = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  rs_drv_state_t state_q;
  logic          target_q;
  logic [RW-1:0] retry_q;
  logic          s_q;
  logic          r_q;
  logic          done_q;
  logic          err_q;

  logic          accept;
  logic          checkPass;
  logic          retryLeft;
  logic          timerLoad;
  logic [CW-1:0] timerLoadVal;
  logic          timerZero;

  assign accept    = cmd_valid && (state_q == IDLE);
  // q == qb can never match target/~target, so it always fails here.
  assign checkPass = (q_fb == target_q) && (qb_fb == ~target_q);
  assign retryLeft = (retry_q < RETRY_MAX);

  // Reload the shared timer on every edge that enters DRIVE or SETTLE,
  // mirroring the transitions taken by the FSM below.
  always_comb begin
    timerLoad    = 1'b0;
    timerLoadVal = PULSE_LOAD;
    case (state_q)
      IDLE: begin
        if (accept && (rs_op_t'(cmd_op) != RS_NOP)) begin
          timerLoad = 1'b1;
        end
      end
      DRIVE: begin
        if (timerZero) begin
          timerLoad    = 1'b1;
          timerLoadVal = SETTLE_LOAD;
        end
      end
      CHECK: begin
        if (!checkPass && retryLeft) begin
          timerLoad = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  rs_drv_timer #(
    .W(CW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timerLoad),
    .load_val(timerLoadVal),
    .zero    (timerZero)
  );

  // Driver FSM with registered outputs. s and r are only ever loaded
  // as target/~target or both zero, so they cannot be high together.
  // err_clr is applied first so that a same-cycle set overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= 1'b0;
      retry_q  <= '0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (rs_op_t'(cmd_op))
              RS_NOP: begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end
              RS_SET: begin
                target_q <= 1'b1;
                retry_q  <= '0;
                s_q      <= 1'b1;
                r_q      <= 1'b0;
                state_q  <= DRIVE;
              end
              RS_RESET: begin
                target_q <= 1'b0;
                retry_q  <= '0;
                s_q      <= 1'b0;
                r_q      <= 1'b1;
                state_q  <= DRIVE;
              end
              RS_TOGGLE: begin
                target_q <= ~q_fb;
                retry_q  <= '0;
                s_q      <= ~q_fb;
                r_q      <= q_fb;
                state_q  <= DRIVE;
              end
              default: begin
              end
            endcase
          end
        end
        DRIVE: begin
          if (timerZero) begin
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (timerZero) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (checkPass) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (retryLeft) begin
            retry_q <= retry_q + 1'b1;
            s_q     <= target_q;
            r_q     <= ~target_q;
            state_q <= DRIVE;
          end else begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign r         = r_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/rs_ff_driver.md
# rs_ff_driver

Command-side controller for the clocked RS flip-flop (`rs_ff`). It accepts set/reset/toggle/no-op commands over a valid/ready handshake and converts each one into a bounded, never-illegal `s`/`r` pulse. After driving, it reads `q`/`qb` back, checks them against the intended state, and retries a bounded number of times. It sits between the safe-comm control logic and any `rs_ff` instance used as a latched status or enable bit.

## Interface
- `PULSE_W`, default 2: cycles `s` or `r` is held high per attempt (≥1).
- `SETTLE_CYC`, default 2: cycles with `s`=`r`=0 before readback (≥1).
- `MAX_RETRY`, default 2: extra attempts after the first failed check (≥0).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_op` in 2: 00 NOP, 01 SET, 10 RESET, 11 TOGGLE.
- `cmd_ready` out 1: high only in IDLE.
- `s` out 1: registered set drive to `rs_ff`.
- `r` out 1: registered reset drive to `rs_ff`.
- `q_fb` in 1: `q` from `rs_ff`, same clock domain.
- `qb_fb` in 1: `qb` from `rs_ff`.
- `done` out 1: one-cycle pulse at command completion.
- `err` out 1: sticky; set on final failed check; cleared by `err_clr` or `rst`.
- `err_clr` in 1: clears `err`; ignored in the cycle `err` is being set (set wins).
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: `cmd_ready`=1. Acceptance is `cmd_valid & cmd_ready` at a rising edge.
  - NOP: go to DONE. No drive.
  - SET: target = 1.
  - RESET: target = 0.
  - TOGGLE: target = ~`q_fb` as sampled at the acceptance edge.
  - SET/RESET/TOGGLE clear the retry counter and go to DRIVE.
- DRIVE: `s`=target, `r`=~target for PULSE_W cycles, then go to SETTLE.
- SETTLE: `s`=`r`=0 for SETTLE_CYC cycles, then go to CHECK.
- CHECK: one cycle. Pass when `q_fb`==target and `qb_fb`==~target.
  - Pass: go to DONE.
  - Fail with retry < MAX_RETRY: increment retry, go to DRIVE.
  - Fail with retry == MAX_RETRY: set `err`, go to DONE.
  - `q_fb`==`qb_fb` always counts as a fail.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Invariant: `s & r` is never 1, in any state, including reset and retry cycles.
- Counters: the pulse/settle counter is $clog2(max(PULSE_W,SETTLE_CYC)+1) bits and reloads on every state entry. The retry counter is $clog2(MAX_RETRY+1) bits. Neither counter wraps.
- `cmd_op` and `cmd_valid` are ignored outside IDLE; commands are never queued.

## Timing
- Reset values: state IDLE, `s`=0, `r`=0, `done`=0, `err`=0, `busy`=0, counters 0. `cmd_ready`=1 in the first cycle after `rst` deasserts.
- Reset mid-operation: at the next edge, `s` and `r` go to 0 and the FSM goes to IDLE. The in-flight command is dropped with no `done`.
- Acceptance at edge N:
  - `s`/`r` high during cycles N+1 through N+PULSE_W.
  - CHECK at cycle N+PULSE_W+SETTLE_CYC+1.
  - `done` at N+PULSE_W+SETTLE_CYC+2.
  - `cmd_ready` back at N+PULSE_W+SETTLE_CYC+3.
  - Each retry adds PULSE_W+SETTLE_CYC+1 cycles.
- NOP: `done` at N+1, `cmd_ready` at N+2.
- With defaults, a clean SET completes with `done` at N+6. The worst case is N+16.
- `err` rises in the same cycle as the failing command's `done`.

## Structure
- Package `rs_drv_pkg`:
  - `rs_op_t` enum (NOP/SET/RESET/TOGGLE).
  - `rs_drv_state_t` enum (IDLE/DRIVE/SETTLE/CHECK/DONE).
  - Op encoding constants.
- One natural sub-module, `rs_drv_timer`: a loadable down-counter with `load`, `load_val` and `zero` outputs, shared by DRIVE and SETTLE.
- Top level holds the FSM, the target/retry registers, the sticky `err`, and the output registers.

## Test plan
- Reset then idle: hold `rst` 3 cycles. Expect all outputs 0 and `cmd_ready`=1 on the first post-reset cycle. `s & r` must stay 0 throughout.
- SET with defaults, real `rs_ff` attached, q=0: accept at N. Expect `s`=1 at N+1..N+2, `r`=0, `done` at N+6, `q_fb`=1, `err`=0.
- TOGGLE twice from q=1: first `done` leaves q=0, second leaves q=1. The target is sampled at each acceptance.
- Stuck feedback (`q_fb`=0, `qb_fb`=1 forced), SET, MAX_RETRY=2: expect 3 `s` pulses, `done` at N+16, `err`=1. `err_clr` then drops `err` next cycle.
- `rst` asserted in the first DRIVE cycle of a RESET: `r`=0 at the next edge, no `done`, `cmd_ready`=1 afterwards. A following NOP gives `done` at +1.
- `cmd_valid` held high with changing `cmd_op` while busy: only the op present at acceptance executes. `cmd_ready`=0 throughout.
